// File: rtl/net_resolver_seq.sv
//--------------------------------------------------------------------------
// Module      : net_resolver_seq
// Description : Registered resolver for a multi-driven four-state net with
//               wire/wand/wor semantics, trireg charge decay and conflicts.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module net_resolver_seq #(
    parameter int W      = 4,
    parameter int NCH    = 3,
    parameter int KIND   = 0,
    parameter int CHARGE = 0,
    parameter int DECAY  = 8,
    parameter int CW     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  drv_en,
    input  logic [NCH*W-1:0] drv_val,
    input  logic [NCH*W-1:0] drv_x,
    input  logic            conflict_clr,
    output logic [W-1:0]    net_val,
    output logic [W-1:0]    net_known,
    output logic [W-1:0]    net_z,
    output logic [W-1:0]    net_charged,
    output logic            conflict_sticky,
    output logic [CW-1:0]   conflict_cnt
);

    localparam int            c_dw    = (DECAY > 0) ? $clog2(DECAY + 1) : 1;
    localparam logic [c_dw-1:0] c_dload = c_dw'(DECAY);
    localparam logic [CW-1:0] c_cmax  = {CW{1'b1}};
    localparam logic [W-1:0]  c_zrst  = (CHARGE != 0) ? '0 : '1;

    logic [W-1:0]            w_has0, w_has1, w_hasx;
    logic [W-1:0]            w_rval, w_rknown, w_conf;
    logic                    w_drv;
    logic [W-1:0]            w_val_nxt, w_known_nxt, w_z_nxt, w_chg_nxt;
    logic [W-1:0][c_dw-1:0]  w_dcnt_nxt;
    logic                    w_event;

    logic [W-1:0]            r_val, r_known, r_z, r_chg;
    logic [W-1:0][c_dw-1:0]  r_dcnt;
    logic                    r_sticky;
    logic [CW-1:0]           r_cnt;

    // Summarise what the active drivers put on each bit: some 0, some 1, some X.
    always_comb begin
        w_has0 = '0;
        w_has1 = '0;
        w_hasx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (drv_en[i]) begin
                for (int b = 0; b < W; b++) begin
                    if (drv_x[i*W + b])
                        w_hasx[b] = 1'b1;
                    else if (drv_val[i*W + b])
                        w_has1[b] = 1'b1;
                    else
                        w_has0[b] = 1'b1;
                end
            end
        end
    end

    assign w_drv = |drv_en;

    generate
        if (KIND == 1) begin : g_wand
            assign w_rknown = w_has0 | ~w_hasx;
            assign w_rval   = ~w_has0;
            assign w_conf   = '0;
        end else if (KIND == 2) begin : g_wor
            assign w_rknown = w_has1 | ~w_hasx;
            assign w_rval   = w_has1;
            assign w_conf   = '0;
        end else begin : g_wire
            // Known drivers that disagree are a conflict even if an X is also present.
            assign w_rknown = ~w_hasx & ~(w_has0 & w_has1);
            assign w_rval   = w_has1;
            assign w_conf   = w_has0 & w_has1;
        end
    endgenerate

    assign w_event = |w_conf;

    always_comb begin
        w_val_nxt   = r_val;
        w_known_nxt = r_known;
        w_z_nxt     = r_z;
        w_chg_nxt   = r_chg;
        w_dcnt_nxt  = r_dcnt;
        for (int b = 0; b < W; b++) begin
            if (w_drv) begin
                w_val_nxt[b]   = w_rval[b];
                w_known_nxt[b] = w_rknown[b];
                w_z_nxt[b]     = 1'b0;
                w_chg_nxt[b]   = 1'b0;
                w_dcnt_nxt[b]  = c_dload;
            end else if (CHARGE == 0) begin
                w_known_nxt[b] = 1'b0;
                w_z_nxt[b]     = 1'b1;
                w_chg_nxt[b]   = 1'b0;
            end else if (r_known[b] && (DECAY == 0 || r_dcnt[b] != '0)) begin
                // Held charge survives one more cycle; the counter tracks remaining life.
                w_chg_nxt[b] = 1'b1;
                w_z_nxt[b]   = 1'b0;
                if (DECAY != 0)
                    w_dcnt_nxt[b] = r_dcnt[b] - 1'b1;
            end else begin
                w_known_nxt[b] = 1'b0;
                w_chg_nxt[b]   = 1'b0;
                w_z_nxt[b]     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val   <= '0;
            r_known <= '0;
            r_z     <= c_zrst;
            r_chg   <= '0;
            r_dcnt  <= '0;
        end else begin
            r_val   <= w_val_nxt;
            r_known <= w_known_nxt;
            r_z     <= w_z_nxt;
            r_chg   <= w_chg_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // A conflict in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_event) begin
            r_sticky <= 1'b1;
            if (conflict_clr)
                r_cnt <= CW'(1);
            else if (r_cnt != c_cmax)
                r_cnt <= r_cnt + 1'b1;
        end else if (conflict_clr) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end
    end

    assign net_val         = r_val;
    assign net_known       = r_known;
    assign net_z           = r_z;
    assign net_charged     = r_chg;
    assign conflict_sticky = r_sticky;
    assign conflict_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_net_resolver_seq.sv
//--------------------------------------------------------------------------
// Module      : tb_net_resolver_seq
// Description : Six resolver configurations on shared drivers, each compared
//               every cycle against a per-bit behavioural model.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module tb_net_resolver_seq;

    localparam int ND = 6;

    logic        clk;
    logic        rst_n;
    logic [2:0]  en;
    logic [11:0] val;
    logic [11:0] xf;
    logic        clr;

    logic [3:0]  o_val   [ND];
    logic [3:0]  o_known [ND];
    logic [3:0]  o_z     [ND];
    logic [3:0]  o_chg   [ND];
    logic        o_stk   [ND];
    logic [7:0]  o_cnt   [ND];
    logic [1:0]  cnt4;

    int kind_p   [ND] = '{0, 1, 2, 0, 0, 1};
    int charge_p [ND] = '{0, 0, 0, 1, 0, 1};
    int decay_p  [ND] = '{8, 8, 8, 3, 8, 0};
    int cmax_p   [ND] = '{255, 255, 255, 255, 3, 255};

    logic [3:0]  m_val   [ND];
    logic [3:0]  m_known [ND];
    logic [3:0]  m_z     [ND];
    logic [3:0]  m_chg   [ND];
    int          m_held  [ND][4];
    int          m_cnt   [ND];
    logic        m_stk   [ND];

    int n_chk  = 0;
    int n_fail = 0;

    net_resolver_seq #(.W(4), .NCH(3), .KIND(0), .CHARGE(0), .DECAY(8), .CW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .drv_en(en), .drv_val(val), .drv_x(xf), .conflict_clr(clr),
        .net_val(o_val[0]), .net_known(o_known[0]), .net_z(o_z[0]), .net_charged(o_chg[0]),
        .conflict_sticky(o_stk[0]), .conflict_cnt(o_cnt[0]));
    net_resolver_seq #(.W(4), .NCH(3), .KIND(1), .CHARGE(0), .DECAY(8), .CW(8)) u1 (
        .clk(clk), .rst_n(rst_n), .drv_en(en), .drv_val(val), .drv_x(xf), .conflict_clr(clr),
        .net_val(o_val[1]), .net_known(o_known[1]), .net_z(o_z[1]), .net_charged(o_chg[1]),
        .conflict_sticky(o_stk[1]), .conflict_cnt(o_cnt[1]));
    net_resolver_seq #(.W(4), .NCH(3), .KIND(2), .CHARGE(0), .DECAY(8), .CW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .drv_en(en), .drv_val(val), .drv_x(xf), .conflict_clr(clr),
        .net_val(o_val[2]), .net_known(o_known[2]), .net_z(o_z[2]), .net_charged(o_chg[2]),
        .conflict_sticky(o_stk[2]), .conflict_cnt(o_cnt[2]));
    net_resolver_seq #(.W(4), .NCH(3), .KIND(0), .CHARGE(1), .DECAY(3), .CW(8)) u3 (
        .clk(clk), .rst_n(rst_n), .drv_en(en), .drv_val(val), .drv_x(xf), .conflict_clr(clr),
        .net_val(o_val[3]), .net_known(o_known[3]), .net_z(o_z[3]), .net_charged(o_chg[3]),
        .conflict_sticky(o_stk[3]), .conflict_cnt(o_cnt[3]));
    net_resolver_seq #(.W(4), .NCH(3), .KIND(0), .CHARGE(0), .DECAY(8), .CW(2)) u4 (
        .clk(clk), .rst_n(rst_n), .drv_en(en), .drv_val(val), .drv_x(xf), .conflict_clr(clr),
        .net_val(o_val[4]), .net_known(o_known[4]), .net_z(o_z[4]), .net_charged(o_chg[4]),
        .conflict_sticky(o_stk[4]), .conflict_cnt(cnt4));
    net_resolver_seq #(.W(4), .NCH(3), .KIND(1), .CHARGE(1), .DECAY(0), .CW(8)) u5 (
        .clk(clk), .rst_n(rst_n), .drv_en(en), .drv_val(val), .drv_x(xf), .conflict_clr(clr),
        .net_val(o_val[5]), .net_known(o_known[5]), .net_z(o_z[5]), .net_charged(o_chg[5]),
        .conflict_sticky(o_stk[5]), .conflict_cnt(o_cnt[5]));

    assign o_cnt[4] = {6'b0, cnt4};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            m_val[k]   = 4'h0;
            m_known[k] = 4'h0;
            m_z[k]     = (charge_p[k] != 0) ? 4'h0 : 4'hF;
            m_chg[k]   = 4'h0;
            m_cnt[k]   = 0;
            m_stk[k]   = 1'b0;
            for (int b = 0; b < 4; b++) m_held[k][b] = 0;
        end
    endtask

    // Resolution from counts of 0/1/X drivers; charge life counted as cycles held.
    task automatic model_step();
        for (int k = 0; k < ND; k++) begin
            bit conf = 0;
            for (int b = 0; b < 4; b++) begin
                int n0 = 0, n1 = 0, nx = 0;
                for (int c = 0; c < 3; c++) begin
                    if (en[c]) begin
                        if (xf[c*4+b])       nx++;
                        else if (val[c*4+b]) n1++;
                        else                 n0++;
                    end
                end
                if (en != 3'b000) begin
                    m_z[k][b] = 1'b0; m_chg[k][b] = 1'b0; m_held[k][b] = 0;
                    case (kind_p[k])
                        1: begin
                            m_known[k][b] = (n0 > 0) || (nx == 0);
                            m_val[k][b]   = (n0 == 0);
                        end
                        2: begin
                            m_known[k][b] = (n1 > 0) || (nx == 0);
                            m_val[k][b]   = (n1 > 0);
                        end
                        default: begin
                            if (n0 > 0 && n1 > 0) conf = 1;
                            m_known[k][b] = (nx == 0) && !(n0 > 0 && n1 > 0);
                            m_val[k][b]   = (n1 > 0);
                        end
                    endcase
                end else if (charge_p[k] == 0) begin
                    m_z[k][b] = 1'b1; m_known[k][b] = 1'b0; m_chg[k][b] = 1'b0;
                end else if (m_known[k][b] && (decay_p[k] == 0 || m_held[k][b] < decay_p[k])) begin
                    m_chg[k][b] = 1'b1;
                    m_held[k][b]++;
                end else begin
                    m_known[k][b] = 1'b0; m_chg[k][b] = 1'b0;
                end
            end
            if (conf) begin
                m_stk[k] = 1'b1;
                m_cnt[k] = clr ? 1 : ((m_cnt[k] < cmax_p[k]) ? m_cnt[k] + 1 : m_cnt[k]);
            end else if (clr) begin
                m_stk[k] = 1'b0;
                m_cnt[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("u%0d.known", k), o_known[k], m_known[k]);
            chk($sformatf("u%0d.val", k), o_val[k] & m_known[k], m_val[k] & m_known[k]);
            chk($sformatf("u%0d.z", k), o_z[k], m_z[k]);
            chk($sformatf("u%0d.charged", k), o_chg[k], m_chg[k]);
            chk($sformatf("u%0d.sticky", k), o_stk[k], m_stk[k]);
            chk($sformatf("u%0d.cnt", k), o_cnt[k], m_cnt[k]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [2:0] e, input logic [11:0] v, input logic [11:0] x, input logic c);
        en  = e;
        val = v;
        xf  = x;
        clr = c;
    endtask

    initial begin
        int idle = 0;
        rst_n = 1'b0;
        drive(3'b000, 12'h0, 12'h0, 1'b0);
        model_reset();
        #12;
        check_all();
        chk("rst.u0.z", o_z[0], 4'hF);
        chk("rst.u3.z", o_z[3], 4'h0);
        rst_n = 1'b1;

        drive(3'b001, 12'h00A, 12'h0, 1'b0);
        cyc();
        chk("single.val", o_val[0], 4'hA);
        chk("single.known", o_known[0], 4'hF);
        chk("single.z", o_z[0], 4'h0);

        drive(3'b011, 12'h08A, 12'h0, 1'b0);
        cyc();
        cyc();
        chk("conf.known", o_known[0], 4'hD);
        chk("conf.sticky", o_stk[0], 1'b1);
        chk("conf.cnt", o_cnt[0], 8'd2);

        drive(3'b001, 12'h00A, 12'h0, 1'b1);
        cyc();
        chk("clr.cnt", o_cnt[0], 8'd0);
        chk("clr.sticky", o_stk[0], 1'b0);

        drive(3'b111, 12'hFAC, 12'h100, 1'b0);
        cyc();
        chk("wand.known", o_known[1], 4'hF);
        chk("wand.val", o_val[1], 4'h8);
        chk("wor.known", o_known[2], 4'hE);
        chk("wor.val", o_val[2] & 4'hE, 4'hE);

        drive(3'b001, 12'h006, 12'h0, 1'b0);
        cyc();
        drive(3'b000, 12'h0, 12'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold.charged", o_chg[3], 4'hF);
            chk("hold.val", o_val[3], 4'h6);
        end
        cyc();
        chk("decay.known", o_known[3], 4'h0);
        chk("decay.charged", o_chg[3], 4'h0);
        chk("forever.charged", o_chg[5], 4'hF);
        chk("release.z", o_z[0], 4'hF);

        drive(3'b001, 12'h006, 12'h0, 1'b0);
        cyc();
        drive(3'b000, 12'h0, 12'h0, 1'b0);
        cyc();
        cyc();
        drive(3'b001, 12'h006, 12'h0, 1'b0);
        cyc();
        drive(3'b000, 12'h0, 12'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reload.charged", o_chg[3], 4'hF);
        end
        cyc();
        chk("reload.decay", o_known[3], 4'h0);

        drive(3'b001, 12'h006, 12'h0, 1'b0);
        cyc();
        drive(3'b000, 12'h0, 12'h0, 1'b0);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst.u3.known", o_known[3], 4'h0);
        chk("arst.u3.charged", o_chg[3], 4'h0);
        #2;
        rst_n = 1'b1;

        drive(3'b011, 12'h08A, 12'h0, 1'b0);
        for (int i = 0; i < 5; i++) cyc();
        chk("sat.cnt", o_cnt[4], 8'd3);
        clr = 1'b1;
        cyc();
        chk("clrconf.cnt4", o_cnt[4], 8'd1);
        chk("clrconf.cnt0", o_cnt[0], 8'd1);
        chk("clrconf.sticky", o_stk[0], 1'b1);

        for (int i = 0; i < 600; i++) begin
            logic [2:0] e;
            if (idle > 0) begin
                e = 3'b000;
                idle--;
            end else if ($urandom_range(0, 5) == 0) begin
                e = 3'b000;
                idle = $urandom_range(0, 5);
            end else begin
                e = 3'($urandom);
            end
            drive(e, 12'($urandom), 12'($urandom & $urandom & $urandom),
                  ($urandom_range(0, 7) == 0));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
